// File: rtl/block_animator.sv
// Block animator: a BLOCK_W x BLOCK_H block bounces horizontally along row Y_ROW.
// The block is erased, moved and redrawn once per frame tick. A stop request freezes it.
module block_animator #(
  parameter int BLOCK_W = 4,
  parameter int BLOCK_H = 4,
  parameter int X_MAX   = 159,
  parameter int Y_ROW   = 100
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic       frame_done,
  input  logic       stop,
  input  logic [2:0] colour_in,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic       busy,
  output logic       halted,
  output logic [7:0] pos_x
);

  localparam logic [3:0] PX_LAST = 4'(BLOCK_W - 1);
  localparam logic [3:0] PY_LAST = 4'(BLOCK_H - 1);
  localparam logic [7:0] X_RIGHT = 8'(X_MAX - BLOCK_W + 1);
  localparam logic [6:0] Y_BASE  = 7'(Y_ROW);

  typedef enum logic [2:0] {IDLE, DRAW, WAIT_FRAME, ERASE, MOVE, HALT} state_t;

  state_t     state_reg, state_next;
  logic       fd_prev_reg;
  logic       dir_reg;
  logic [7:0] pos_x_reg;
  logic [3:0] px_reg, py_reg;
  logic       tick, walking, last_pixel;

  assign tick       = frame_done & ~fd_prev_reg;
  assign walking    = (state_reg == ERASE) || (state_reg == DRAW);
  assign last_pixel = (px_reg == PX_LAST) && (py_reg == PY_LAST);
  assign pos_x      = pos_x_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:       if (go) state_next = DRAW;
      DRAW:       if (last_pixel) state_next = WAIT_FRAME;
      WAIT_FRAME: begin
        if (stop)      state_next = HALT;
        else if (tick) state_next = ERASE;
      end
      ERASE:      if (last_pixel) state_next = MOVE;
      MOVE:       state_next = DRAW;
      HALT:       state_next = HALT;
      default:    state_next = IDLE;
    endcase
  end

  // Pixel walk is cleared in every non-walking state, so each ERASE/DRAW starts at (0,0).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fd_prev_reg <= 1'b0;
      px_reg      <= '0;
      py_reg      <= '0;
      pos_x_reg   <= '0;
      dir_reg     <= 1'b0;
    end else begin
      fd_prev_reg <= frame_done;
      if (walking && !last_pixel) begin
        if (px_reg == PX_LAST) begin
          px_reg <= '0;
          py_reg <= py_reg + 4'd1;
        end else begin
          px_reg <= px_reg + 4'd1;
        end
      end else begin
        px_reg <= '0;
        py_reg <= '0;
      end
      if (state_reg == MOVE) begin
        if (!dir_reg) begin
          if (pos_x_reg == X_RIGHT) begin
            dir_reg   <= 1'b1;
            pos_x_reg <= pos_x_reg - 8'd1;
          end else begin
            pos_x_reg <= pos_x_reg + 8'd1;
          end
        end else begin
          if (pos_x_reg == 8'd0) begin
            dir_reg   <= 1'b0;
            pos_x_reg <= pos_x_reg + 8'd1;
          end else begin
            pos_x_reg <= pos_x_reg - 8'd1;
          end
        end
      end
    end
  end

  always_comb begin
    plot       = 1'b0;
    busy       = 1'b0;
    halted     = 1'b0;
    colour_out = 3'd0;
    x_out      = pos_x_reg;
    y_out      = Y_BASE;
    case (state_reg)
      ERASE: begin
        plot  = 1'b1;
        busy  = 1'b1;
        x_out = pos_x_reg + {4'd0, px_reg};
        y_out = Y_BASE + {3'd0, py_reg};
      end
      DRAW: begin
        plot       = 1'b1;
        busy       = 1'b1;
        colour_out = colour_in;
        x_out      = pos_x_reg + {4'd0, px_reg};
        y_out      = Y_BASE + {3'd0, py_reg};
      end
      MOVE:    busy   = 1'b1;
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_block_animator.sv
// Directed bench for block_animator: vector table for draw/erase/move walks,
// hand-written sequences for bounce, dropped ticks, mid-walk reset and halt.
module tb_block_animator;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       go = 1'b0;
  logic       frame_done = 1'b0;
  logic       stop = 1'b0;
  logic [2:0] colour_in = 3'd0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot, busy, halted;
  logic [7:0] pos_x;

  int errors = 0;
  int checks = 0;

  block_animator dut (
    .clk(clk), .resetn(resetn), .go(go), .frame_done(frame_done), .stop(stop),
    .colour_in(colour_in), .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
    .plot(plot), .busy(busy), .halted(halted), .pos_x(pos_x)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       go;
    logic       fd;
    logic [2:0] col;
    logic       e_plot;
    logic       e_busy;
    logic [7:0] e_x;
    logic [6:0] e_y;
    logic [2:0] e_col;
  } vec_t;

  localparam int NV = 54;
  vec_t vecs [NV];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_plot"}, int'(plot), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_halted"}, int'(halted), 0);
    check({tag, "_colour"}, int'(colour_out), 0);
    check({tag, "_x"}, int'(x_out), 0);
    check({tag, "_y"}, int'(y_out), 100);
    check({tag, "_pos_x"}, int'(pos_x), 0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    check({tag, "_done_in_time"}, int'(busy), 0);
  endtask

  // One frame_done pulse from WAIT_FRAME; walk must start next cycle and finish.
  task automatic do_tick(input string tag);
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    check({tag, "_start"}, int'(plot), 1);
    wait_idle(tag);
  endtask

  initial begin
    // Initial draw with colour 6 from (0,100) to (3,103), then WAIT_FRAME.
    for (int k = 0; k < 16; k++)
      vecs[k] = '{(k == 0), 1'b0, 3'd6, 1'b1, 1'b1, 8'(k % 4), 7'(100 + k / 4), 3'd6};
    vecs[16] = '{1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 8'd0, 7'd100, 3'd0};
    // frame_done held 20 cycles: erase x 0..3, move, draw x 1..4, single sequence only.
    for (int k = 0; k < 16; k++)
      vecs[17 + k] = '{1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 8'(k % 4), 7'(100 + k / 4), 3'd0};
    vecs[33] = '{1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 8'd0, 7'd100, 3'd0};
    for (int k = 0; k < 16; k++)
      vecs[34 + k] = '{1'b0, (34 + k < 37), 3'd5, 1'b1, 1'b1, 8'(1 + k % 4), 7'(100 + k / 4), 3'd5};
    for (int k = 50; k < NV; k++)
      vecs[k] = '{1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 8'd1, 7'd100, 3'd0};

    // Reset state
    #1;
    check_reset_outputs("reset");
    step();
    step();
    check_reset_outputs("reset_held");
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      go = vecs[i].go;
      frame_done = vecs[i].fd;
      colour_in = vecs[i].col;
      step();
      check($sformatf("vec%0d_plot", i), int'(plot), int'(vecs[i].e_plot));
      check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
      check($sformatf("vec%0d_x", i), int'(x_out), int'(vecs[i].e_x));
      check($sformatf("vec%0d_y", i), int'(y_out), int'(vecs[i].e_y));
      check($sformatf("vec%0d_colour", i), int'(colour_out), int'(vecs[i].e_col));
    end
    go = 1'b0;
    frame_done = 1'b0;
    check("after_seq_pos_x", int'(pos_x), 1);

    // Tick arriving during DRAW is dropped.
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    for (int k = 0; k < 18; k++) step();
    check("draw_tick_in_draw", int'(plot) & int'(busy), 1);
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    wait_idle("draw_tick");
    begin
      int plots;
      plots = 0;
      for (int k = 0; k < 10; k++) begin
        step();
        if (plot) plots++;
      end
      check("draw_tick_dropped_plots", plots, 0);
    end
    check("draw_tick_pos_x", int'(pos_x), 2);
    do_tick("after_drop");
    check("after_drop_pos_x", int'(pos_x), 3);

    // Right bounce at 156, then left bounce at 0.
    for (int n = 0; n < 200 && pos_x != 8'd156; n++) do_tick("walk_right");
    check("reach_right", int'(pos_x), 156);
    do_tick("bounce_r");
    check("bounce_right_pos_x", int'(pos_x), 155);
    do_tick("bounce_r2");
    check("after_right_dir_left", int'(pos_x), 154);
    for (int n = 0; n < 200 && pos_x != 8'd0; n++) do_tick("walk_left");
    check("reach_left", int'(pos_x), 0);
    do_tick("bounce_l");
    check("bounce_left_pos_x", int'(pos_x), 1);
    do_tick("bounce_l2");
    check("after_left_dir_right", int'(pos_x), 2);

    // Reset at the 7th ERASE pixel.
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check("erase7_plot", int'(plot), 1);
    check("erase7_x", int'(x_out), 4);
    check("erase7_y", int'(y_out), 101);
    resetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    step();
    check_reset_outputs("midreset_held");
    resetn = 1'b1;
    step();
    check("midreset_idle_plot", int'(plot), 0);
    go = 1'b1;
    colour_in = 3'd3;
    step();
    go = 1'b0;
    check("redraw_plot", int'(plot), 1);
    check("redraw_x", int'(x_out), 0);
    check("redraw_y", int'(y_out), 100);
    check("redraw_colour", int'(colour_out), 3);
    wait_idle("redraw");

    // stop and frame_done rise together in WAIT_FRAME: HALT wins.
    stop = 1'b1;
    frame_done = 1'b1;
    step();
    stop = 1'b0;
    frame_done = 1'b0;
    check("halt_halted", int'(halted), 1);
    check("halt_plot", int'(plot), 0);
    check("halt_busy", int'(busy), 0);
    for (int k = 0; k < 10; k++) begin
      go = k[0];
      frame_done = k[1];
      step();
      check($sformatf("halt_hold%0d", k), int'(halted) + 2 * int'(plot), 1);
    end
    go = 1'b0;
    frame_done = 1'b0;
    check("halt_pos_x", int'(pos_x), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/block_animator.md
BLOCK_ANIMATOR -- requirements
Module: block_animator

Interface
REQ-001 Parameter BLOCK_W, default 4: block width in pixels; power of two, 1..8.
REQ-002 Parameter BLOCK_H, default 4: block height in pixels; power of two, 1..8.
REQ-003 Parameter X_MAX, default 159: rightmost legal screen column.
REQ-004 Parameter Y_ROW, default 100: fixed top row of the block.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 go  input  1  start request; sampled only in IDLE.
REQ-008 frame_done  input  1  level from the frame counter; high while its count is at terminal value.
REQ-009 stop  input  1  player drop request; level, sampled per REQ-021.
REQ-010 colour_in  input  3  block colour used for DRAW.
REQ-011 x_out  output  8  pixel column to plot.
REQ-012 y_out  output  7  pixel row to plot.
REQ-013 colour_out  output  3  pixel colour to plot.
REQ-014 plot  output  1  high for exactly one cycle per pixel written.
REQ-015 busy  output  1  high in ERASE, MOVE and DRAW.
REQ-016 halted  output  1  high in HALT.
REQ-017 pos_x  output  8  current block left column.

Function
REQ-018 States: IDLE, DRAW, WAIT_FRAME, ERASE, MOVE, HALT; single registered FSM.
REQ-019 IDLE: go=1 -> DRAW (initial draw); else stay.
REQ-020 frame_done is edge-detected with a registered copy; a "tick" is a 0->1 transition. A level held high across many cycles yields one tick.
REQ-021 WAIT_FRAME: stop=1 -> HALT (stop has priority over a same-cycle tick); else tick -> ERASE; else stay.
REQ-022 Ticks arriving outside WAIT_FRAME are dropped, not queued.
REQ-023 stop asserted during DRAW, ERASE or MOVE takes effect in the first WAIT_FRAME cycle if still high; it is not latched.
REQ-024 ERASE: BLOCK_W*BLOCK_H consecutive cycles, plot=1, colour_out=0, x_out=pos_x+px, y_out=Y_ROW+py; px increments fastest, py advances when px wraps from BLOCK_W-1 to 0.
REQ-025 After the last ERASE pixel -> MOVE (one cycle, plot=0).
REQ-026 MOVE: direction register dir (0=right, 1=left). Right: if pos_x == X_MAX-BLOCK_W+1, set dir=1 and pos_x-1; else pos_x+1. Left: if pos_x == 0, set dir=0 and pos_x+1; else pos_x-1. Then -> DRAW.
REQ-027 DRAW: identical pixel walk to ERASE with colour_out=colour_in, sampled each cycle; after the last pixel -> WAIT_FRAME.
REQ-028 Pixel counter resets to 0 on every entry to ERASE or DRAW.
REQ-029 Outside ERASE/DRAW: plot=0, colour_out=0, x_out=pos_x, y_out=Y_ROW.
REQ-030 HALT: absorbing until reset; pos_x frozen; plot=0; go, stop and frame_done ignored.
REQ-031 Latency: first ERASE pixel plot is in the cycle after the tick is detected; erase, move, redraw cycle length is 2*BLOCK_W*BLOCK_H+1 cycles.
REQ-032 x_out/y_out arithmetic is unsigned at output width; no wrap can occur for legal parameters.

Reset
REQ-033 resetn=0 immediately forces state=IDLE, pos_x=0, dir=0, pixel counter=0, edge register=0, plot=0, busy=0, halted=0, colour_out=0, x_out=0, y_out=Y_ROW.
REQ-034 Reset mid-ERASE or mid-DRAW aborts the walk with no further plots; the partial block is not cleaned up.
REQ-035 Reset release needs no synchronisation inside the block; the first state change occurs on the first clk edge with resetn=1.

Verification
REQ-036 Reset, go=1 one cycle -> 16 plots, colour_out=colour_in, (x,y) from (0,100) to (3,103) in x-fastest order, then WAIT_FRAME, busy=0.
REQ-037 In WAIT_FRAME with pos_x=0, frame_done 0->1 held 20 cycles -> one sequence: 16 plots of colour 0 at x 0..3, one MOVE cycle, 16 plots at x 1..4; pos_x=1; no second sequence.
REQ-038 Bounce: pos_x driven to 156 with dir=0, then a tick -> pos_x=155, dir=1; with pos_x=0 and dir=1, then a tick -> pos_x=1, dir=0.
REQ-039 stop=1 and a frame_done rise in the same WAIT_FRAME cycle -> HALT, halted=1, no plot; later go and frame_done pulses -> no change.
REQ-040 resetn=0 at the 7th ERASE pixel -> plot=0 in the same cycle, all outputs at REQ-033 values; after release and go, the initial draw starts at x=0.
REQ-041 Tick arriving during DRAW -> ignored; the next sequence starts only on the following frame_done rise in WAIT_FRAME.
